// File: rtl/spi_periph_pkg.sv
// spi_periph_pkg
//   Shared definitions for the SPI register-file peripheral:
//   - state_t    : frame FSM states (IDLE, ADDR, DATA, COMMIT)
//   - RW_WRITE / RW_READ : values of the leading R/W bit of a frame
//   - frame_bits : total bits in one frame (R/W + address + data)
package spi_periph_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    COMMIT
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int frame_bits(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync
//   Brings one asynchronous pin into the clk domain through a 2-FF
//   synchroniser and derives single-cycle edge pulses from the
//   synchronised level.
//   Parameters:
//     RST_VAL : value loaded into every stage while rst is high
//   Ports:
//     clk   in  : system clock
//     rst   in  : synchronous, active-high reset
//     pin   in  : asynchronous pin
//     level out : synchronised level
//     rise  out : one-cycle pulse on a synchronised 0->1 transition
//     fall  out : one-cycle pulse on a synchronised 1->0 transition
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= pin;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_regfile_periph.sv
// spi_regfile_periph
//   SPI mode-0 peripheral with an internal register file. Frames are
//   MSB first: R/W bit (1 = write), ADDR_W address bits, DATA_W data bits.
//   All SPI pins are oversampled in the clk domain.
//   Optional feature macro: SPI_PERIPH_READBACK_EN
//     defined   : read frames shift regs[addr] out on cipo
//     undefined : cipo tied to 0, read frames are discarded
//   Parameters: NUM_REGS, DATA_W, ADDR_W
//   Ports:
//     clk       in  : system clock
//     rst       in  : synchronous, active-high reset
//     cs_n      in  : chip select, active low (async)
//     sclk      in  : SPI clock (async)
//     copi      in  : controller-out data (async)
//     cipo      out : peripheral-out data, registered
//     regs      out : flattened register file, reg i at [i*DATA_W +: DATA_W]
//     wr_strobe out : one-cycle pulse when a write commits
//     wr_addr   out : address of the last committed write
module spi_regfile_periph
  import spi_periph_pkg::*;
#(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cs_n,
  input  logic                       sclk,
  input  logic                       copi,
  output logic                       cipo,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr
);

  localparam int FRAME_BITS = frame_bits(ADDR_W, DATA_W);
  localparam int CMD_BITS   = 1 + ADDR_W;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  localparam logic [CNT_W-1:0]  CNT_FRAME    = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_LAST_CMD = CNT_W'(CMD_BITS - 1);
  localparam logic [ADDR_W:0]   NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);

  // Pin synchronisers. cs_n resets to "selected" so that a cs_n already
  // low at reset release produces no falling edge, and a cs_n that is
  // high only produces a rising edge, which IDLE ignores.
  logic cs_rise, cs_fall, cs_level_unused;
  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic copi_lvl, copi_rise_unused, copi_fall_unused;

  spi_pin_sync #(.RST_VAL(1'b0)) u_sync_cs (
    .clk   (clk),
    .rst   (rst),
    .pin   (cs_n),
    .level (cs_level_unused),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_pin_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst   (rst),
    .pin   (sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_pin_sync #(.RST_VAL(1'b0)) u_sync_copi (
    .clk   (clk),
    .rst   (rst),
    .pin   (copi),
    .level (copi_lvl),
    .rise  (copi_rise_unused),
    .fall  (copi_fall_unused)
  );

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [CMD_BITS-1:0]    cmd_sr_q;
  logic [CMD_BITS-1:0]    cmd_next;
  logic [DATA_W-1:0]      data_sr_q;
  logic                   ovf_q;
  logic [DATA_W-1:0]      reg_q [NUM_REGS];
  logic                   wr_strobe_q;
  logic [ADDR_W-1:0]      wr_addr_q;

  logic                   rw_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   addr_ok;

  logic frame_start, cmd_shift, data_shift, cnt_inc, ovf_set;
  logic load_sout, out_shift, commit;

  assign cmd_next = {cmd_sr_q[CMD_BITS-2:0], copi_lvl};
  assign rw_q     = cmd_sr_q[CMD_BITS-1];
  assign addr_q   = cmd_sr_q[ADDR_W-1:0];
  assign addr_ok  = ({1'b0, addr_q} < NUM_REGS_EXT);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A cs_n edge takes priority over any sclk edge seen in the same cycle.
  // The write commits on the same edge that enters COMMIT so that regs
  // and wr_strobe follow the cs_n rise with the two-cycle sync latency.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    cmd_shift   = 1'b0;
    data_shift  = 1'b0;
    cnt_inc     = 1'b0;
    ovf_set     = 1'b0;
    load_sout   = 1'b0;
    out_shift   = 1'b0;
    commit      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d     = ADDR;
          frame_start = 1'b1;
        end
      end
      ADDR: begin
        if (cs_rise) begin
          state_d = COMMIT;
        end else if (sclk_rise) begin
          cmd_shift = 1'b1;
          cnt_inc   = 1'b1;
          if (bit_cnt_q == CNT_LAST_CMD) begin
            state_d   = DATA;
            load_sout = (cmd_next[CMD_BITS-1] == RW_READ);
          end
        end
      end
      DATA: begin
        if (cs_rise) begin
          state_d = COMMIT;
          commit  = (rw_q == RW_WRITE) && (bit_cnt_q == CNT_FRAME) &&
                    addr_ok && !ovf_q;
        end else begin
          if (sclk_rise) begin
            if (bit_cnt_q == CNT_FRAME) begin
              ovf_set = 1'b1;
            end else begin
              cnt_inc    = 1'b1;
              data_shift = (rw_q == RW_WRITE);
            end
          end
          if (sclk_fall && (rw_q == RW_READ)) out_shift = 1'b1;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      cmd_sr_q    <= '0;
      data_sr_q   <= '0;
      ovf_q       <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
    end else begin
      wr_strobe_q <= commit;
      if (frame_start) begin
        bit_cnt_q <= '0;
        cmd_sr_q  <= '0;
        data_sr_q <= '0;
        ovf_q     <= 1'b0;
      end
      if (cnt_inc)    bit_cnt_q <= bit_cnt_q + 1'b1;
      if (cmd_shift)  cmd_sr_q  <= cmd_next;
      if (data_shift) data_sr_q <= {data_sr_q[DATA_W-2:0], copi_lvl};
      if (ovf_set)    ovf_q     <= 1'b1;
      if (commit) begin
        wr_addr_q <= addr_q;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (addr_q == ADDR_W'(i)) reg_q[i] <= data_sr_q;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs[g*DATA_W +: DATA_W] = reg_q[g];
  end

  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;

`ifdef SPI_PERIPH_READBACK_EN
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] sout_q;
  logic              cipo_q;

  // Out-of-range addresses fall through to zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_next[ADDR_W-1:0] == ADDR_W'(i)) rd_word = reg_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sout_q <= '0;
      cipo_q <= 1'b0;
    end else begin
      if (load_sout)      sout_q <= rd_word;
      else if (out_shift) sout_q <= sout_q << 1;
      if (out_shift)           cipo_q <= sout_q[DATA_W-1];
      else if (state_d != DATA) cipo_q <= 1'b0;
    end
  end

  assign cipo = cipo_q;
`else
  logic readback_unused;
  assign readback_unused = load_sout ^ out_shift;
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_periph.sv
// tb_spi_regfile_periph
//   Directed bench for spi_regfile_periph with default parameters.
//   Frames are driven with sclk half periods of 4 clk cycles.
module tb_spi_regfile_periph;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_n = 1'b1;
  logic        sclk = 1'b0;
  logic        copi = 1'b0;
  logic        cipo;
  logic [39:0] regs;
  logic        wr_strobe;
  logic [6:0]  wr_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_regfile_periph #(
    .NUM_REGS (5),
    .DATA_W   (8),
    .ADDR_W   (7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cs_n      (cs_n),
    .sclk      (sclk),
    .copi      (copi),
    .cipo      (cipo),
    .regs      (regs),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shifts frame[nbits-1:0] MSB first. Bits 8..15 of cipo are captured
  // just before each data-phase sclk rise. When raise is set, cs_n is
  // released afterwards and wr_strobe high cycles are counted.
  task automatic xfer(input logic [31:0] frame, input int nbits, input bit raise,
                      output logic [7:0] rd, output int pulses);
    rd = 8'h00;
    pulses = 0;
    @(negedge clk);
    cs_n = 1'b0;
    wait_cycles(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = frame[i];
      wait_cycles(4);
      if ((nbits - 1 - i) >= 8 && (nbits - 1 - i) < 16) rd = {rd[6:0], cipo};
      sclk = 1'b1;
      wait_cycles(4);
      sclk = 1'b0;
    end
    copi = 1'b0;
    if (raise) begin
      wait_cycles(4);
      cs_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (wr_strobe) pulses++;
      end
    end
  endtask

  logic [7:0] rd;
  int         pulses;
  logic [7:0] exp_rd_a5;
  logic [7:0] exp_rd_11;

  initial begin
`ifdef SPI_PERIPH_READBACK_EN
    exp_rd_a5 = 8'hA5;
    exp_rd_11 = 8'h11;
`else
    exp_rd_a5 = 8'h00;
    exp_rd_11 = 8'h00;
`endif

    // Reset with cs_n high
    wait_cycles(4);
    rst = 1'b0;
    wait_cycles(6);
    check("reset_regs", 64'(regs), 64'h0);
    check("reset_cipo", 64'(cipo), 64'h0);
    check("reset_strobe", 64'(wr_strobe), 64'h0);
    check("reset_wr_addr", 64'(wr_addr), 64'h0);

    // Write 0x82A5
    xfer(32'h82A5, 16, 1'b1, rd, pulses);
    check("w82A5_regs", 64'(regs), 64'h00_00_A5_00_00);
    check("w82A5_pulses", 64'(pulses), 64'd1);
    check("w82A5_wr_addr", 64'(wr_addr), 64'd2);

    // Read 0x0200
    xfer(32'h0200, 16, 1'b1, rd, pulses);
    check("r0200_data", 64'(rd), 64'(exp_rd_a5));
    check("r0200_pulses", 64'(pulses), 64'd0);
    check("r0200_regs", 64'(regs), 64'h00_00_A5_00_00);
    check("r0200_cipo_idle", 64'(cipo), 64'h0);

    // Write to out-of-range address 5
    xfer(32'h85FF, 16, 1'b1, rd, pulses);
    check("w85FF_regs", 64'(regs), 64'h00_00_A5_00_00);
    check("w85FF_pulses", 64'(pulses), 64'd0);
    check("w85FF_wr_addr", 64'(wr_addr), 64'd2);

    // Read out-of-range address 5
    xfer(32'h0500, 16, 1'b1, rd, pulses);
    check("r0500_data", 64'(rd), 64'h00);

    // Aborted after 10 bits of 0x813C
    xfer(32'h813C >> 6, 10, 1'b1, rd, pulses);
    check("abort10_regs", 64'(regs), 64'h00_00_A5_00_00);
    check("abort10_pulses", 64'(pulses), 64'd0);

    // 17 bits: overflow discards the frame
    xfer({15'h0, 16'h813C, 1'b1}, 17, 1'b1, rd, pulses);
    check("ovf17_regs", 64'(regs), 64'h00_00_A5_00_00);
    check("ovf17_pulses", 64'(pulses), 64'd0);

    // Clean 0x813C after the discarded frames
    xfer(32'h813C, 16, 1'b1, rd, pulses);
    check("w813C_regs", 64'(regs), 64'h00_00_A5_3C_00);
    check("w813C_pulses", 64'(pulses), 64'd1);
    check("w813C_wr_addr", 64'(wr_addr), 64'd1);

    // Reset after 8 bits of 0x84FF, cs_n still low at release
    xfer(32'h84, 8, 1'b0, rd, pulses);
    rst = 1'b1;
    wait_cycles(3);
    check("midrst_regs", 64'(regs), 64'h0);
    check("midrst_wr_addr", 64'(wr_addr), 64'h0);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (wr_strobe) pulses++;
    end
    cs_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (wr_strobe) pulses++;
    end
    check("midrst_no_strobe", 64'(pulses), 64'd0);
    check("midrst_regs_after", 64'(regs), 64'h0);

    xfer(32'h8411, 16, 1'b1, rd, pulses);
    check("w8411_regs", 64'(regs), 64'h11_00_00_00_00);
    check("w8411_pulses", 64'(pulses), 64'd1);
    check("w8411_wr_addr", 64'(wr_addr), 64'd4);

    // Read back register 4
    xfer(32'h0400, 16, 1'b1, rd, pulses);
    check("r0400_data", 64'(rd), 64'(exp_rd_11));
    check("r0400_regs", 64'(regs), 64'h11_00_00_00_00);
    check("r0400_cipo_idle", 64'(cipo), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
